// File: rtl/task_no_of_0s.sv
// Zero-bit population counter: combinational count of 0 bits in a_in plus a
// registered copy with all-zero/all-ones flags and a post-reset valid flag.
module task_no_of_0s #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a_in,
    output logic [CNT_W-1:0] np_of_0s,
    output logic [CNT_W-1:0] np_of_1s,
    output logic [CNT_W-1:0] cnt0_q,
    output logic [CNT_W-1:0] cnt1_q,
    output logic             all_zero_q,
    output logic             all_ones_q,
    output logic             valid_q
);

    localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

    // X/Z bits fail the == 1'b0 test, so they are never counted as zeros.
    task automatic count_zeros(input logic [WIDTH-1:0] word,
                               output logic [CNT_W-1:0] cnt);
        cnt = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (word[i] == 1'b0) begin
                cnt = cnt + CNT_W'(1);
            end
        end
    endtask

    logic [CNT_W-1:0] cnt0_d;
    logic [CNT_W-1:0] cnt1_d;
    logic             all_zero_d;
    logic             all_ones_d;

    always_comb begin
        np_of_0s = '0;
        count_zeros(a_in, np_of_0s);
        np_of_1s = WIDTH_C - np_of_0s;
    end

    always_comb begin
        cnt0_d     = np_of_0s;
        cnt1_d     = np_of_1s;
        all_zero_d = (np_of_0s == WIDTH_C);
        all_ones_d = (np_of_0s == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q     <= '0;
            cnt1_q     <= '0;
            all_zero_q <= 1'b0;
            all_ones_q <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            cnt0_q     <= cnt0_d;
            cnt1_q     <= cnt1_d;
            all_zero_q <= all_zero_d;
            all_ones_q <= all_ones_d;
            valid_q    <= 1'b1;
        end
    end

endmodule

// File: tb/tb_task_no_of_0s.sv
// Directed bench for task_no_of_0s: combinational counts checked against a
// $countones reference, registered outputs checked through an expectation queue.
module tb_task_no_of_0s;

    logic       clk;
    logic       rst;
    logic [7:0] a_in;
    logic [3:0] np_of_0s;
    logic [3:0] np_of_1s;
    logic [3:0] cnt0_q;
    logic [3:0] cnt1_q;
    logic       all_zero_q;
    logic       all_ones_q;
    logic       valid_q;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] c0;
        logic [3:0] c1;
        logic       az;
        logic       ao;
        logic       v;
    } exp_t;

    exp_t sb_q[$];

    task_no_of_0s #(.WIDTH(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .np_of_0s  (np_of_0s),
        .np_of_1s  (np_of_1s),
        .cnt0_q    (cnt0_q),
        .cnt1_q    (cnt1_q),
        .all_zero_q(all_zero_q),
        .all_ones_q(all_ones_q),
        .valid_q   (valid_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] ref_zeros(input logic [7:0] v);
        return 4'(8 - $countones(v));
    endfunction

    task automatic check_comb(input logic [7:0] v);
        check($sformatf("np_of_0s[%02h]", v), 32'(np_of_0s), 32'(ref_zeros(v)));
        check($sformatf("np_of_1s[%02h]", v), 32'(np_of_1s), 32'($countones(v)));
        check($sformatf("sum[%02h]", v), 32'(np_of_0s) + 32'(np_of_1s), 32'd8);
    endtask

    // Drive one word on the falling edge, check the combinational path, queue
    // the registered expectation and compare it after the next rising edge.
    task automatic apply(input logic [7:0] v, input logic r);
        exp_t e;
        exp_t got;
        @(negedge clk);
        a_in = v;
        rst  = r;
        #1;
        check_comb(v);
        if (r) begin
            e = '{c0: 4'd0, c1: 4'd0, az: 1'b0, ao: 1'b0, v: 1'b0};
        end else begin
            e.c0 = ref_zeros(v);
            e.c1 = 4'($countones(v));
            e.az = (v == 8'h00);
            e.ao = (v == 8'hFF);
            e.v  = 1'b1;
        end
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            got = sb_q.pop_front();
            check($sformatf("cnt0_q[%02h]", v), 32'(cnt0_q), 32'(got.c0));
            check($sformatf("cnt1_q[%02h]", v), 32'(cnt1_q), 32'(got.c1));
            check($sformatf("all_zero_q[%02h]", v), 32'(all_zero_q), 32'(got.az));
            check($sformatf("all_ones_q[%02h]", v), 32'(all_ones_q), 32'(got.ao));
            check($sformatf("valid_q[%02h]", v), 32'(valid_q), 32'(got.v));
        end
    endtask

    initial begin
        rst  = 1'b1;
        a_in = 8'h00;
        #1;
        check("comb_before_clock_0s", 32'(np_of_0s), 32'd8);
        check("comb_before_clock_1s", 32'(np_of_1s), 32'd0);

        apply(8'h00, 1'b1);
        apply(8'h00, 1'b1);

        apply(8'h00, 1'b0);
        apply(8'hFF, 1'b0);
        apply(8'h00, 1'b0);

        apply(8'h01, 1'b0);
        apply(8'h80, 1'b0);
        apply(8'hA5, 1'b0);
        apply(8'h0F, 1'b0);
        apply(8'hFE, 1'b0);
        apply(8'h7F, 1'b0);

        for (int i = 0; i < 50; i++) begin
            apply(8'(i), 1'b0);
        end

        for (int i = 0; i < 256; i++) begin
            apply(8'(i), 1'b0);
        end

        apply(8'h0F, 1'b0);
        apply(8'h0F, 1'b0);
        apply(8'h0F, 1'b1);
        apply(8'h0F, 1'b0);
        apply(8'hFF, 1'b0);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/task_no_of_0s.md
Name: task_no_of_0s

Overview:
- Zero-bit population counter: reports how many bits of an 8-bit input word are 0.
- Provides a zero-latency combinational count (primary output) and a registered copy with status flags for synchronous consumers.
- Counting logic is implemented as a reusable Verilog task, looped over the input bits.
- Leaf datapath utility; no handshake, accepts a new word every cycle.

Parameters:
- WIDTH, 8, input word width in bits (≥1).
- CNT_W, 4, count width; must satisfy 2^CNT_W > WIDTH (4 for WIDTH=8).

Ports:
- clk  input  1  system clock; rising-edge active.
- rst  input  1  synchronous reset, active-high.
- a_in  input  WIDTH  data word to examine.
- np_of_0s  output  CNT_W  combinational count of 0 bits in a_in.
- np_of_1s  output  CNT_W  combinational count of 1 bits (WIDTH − np_of_0s).
- cnt0_q  output  CNT_W  registered np_of_0s.
- cnt1_q  output  CNT_W  registered np_of_1s.
- all_zero_q  output  1  registered flag: a_in was 0 (cnt0 == WIDTH).
- all_ones_q  output  1  registered flag: a_in was all ones (cnt0 == 0).
- valid_q  output  1  high from the first clock edge after reset deassertion onward.

Behaviour:
- Reset is synchronous and active-high: clk is the only clock; rst is sampled on the rising edge of clk.
- Combinational path:
  - np_of_0s = number of bit positions i in [0, WIDTH-1] with a_in[i] == 0.
  - It is updated in the same delta as a_in; no clock dependence and no reset dependence.
  - Computed in a task that clears an accumulator, loops over all WIDTH bits and increments on each 0.
  - np_of_1s = WIDTH − np_of_0s, computed at CNT_W bits with no overflow possible.
  - Range 0..WIDTH; for WIDTH=8 the values 9..15 never appear.
  - X/Z bits in a_in are not counted as 0; simulation behaviour for X inputs is don't-care.
- Registered path:
  - On a rising edge with rst=1: cnt0_q=0, cnt1_q=0, all_zero_q=0, all_ones_q=0, valid_q=0.
  - On a rising edge with rst=0: cnt0_q←np_of_0s, cnt1_q←np_of_1s, all_zero_q←(np_of_0s==WIDTH), all_ones_q←(np_of_0s==0), valid_q←1.
  - Latency is exactly 1 clock; throughput is one word per clock.
  - Reset asserted mid-stream clears all registered outputs on that edge; the combinational outputs keep tracking a_in.
  - First edge after rst falls: registered outputs reflect the a_in sampled at that edge, and valid_q=1.
- Boundaries:
  - a_in=0 → count WIDTH, all_zero.
  - a_in all ones → count 0, all_ones.
  - a_in wrap-around from 0xFF to 0x00 → the combinational count jumps from 0 to 8 immediately.
- No latches and no internal state besides the listed registers.

Test Plan:
- a_in=8'h00, no clock → np_of_0s=8 and np_of_1s=0 immediately; after one edge with rst=0: cnt0_q=8, all_zero_q=1, valid_q=1.
- a_in=8'hFF → np_of_0s=0, np_of_1s=8; after an edge: cnt0_q=0, all_ones_q=1, all_zero_q=0.
- Spot values: 8'h01→7, 8'h80→7, 8'hA5→4, 8'h0F→4, 8'hFE→1, 8'h7F→1; each is checked combinationally and, after one edge, on cnt0_q.
- Incrementing sweep: a_in starts at 0 and increments every 10 ns for 500 ns (0x00..0x31) → np_of_0s equals 8 − popcount(a_in) at every step, including 0x00→8, 0x03→6 and 0x1F→3.
- Exhaustive: all 256 values of a_in, one per clock → np_of_0s + np_of_1s == 8 always, and cnt0_q matches the previous cycle's np_of_0s.
- Reset mid-operation: with a_in=8'h0F streaming, assert rst for one edge → all registered outputs are 0 and valid_q=0 while np_of_0s stays 4; on the next edge after rst=0, cnt0_q=4 and valid_q=1.
